core_ctrl: RTL

- Multi-cycle sequencing controller for the single-issue core.
- Owns the PC and fetches instructions over a valid/ready instruction-memory port, latching each one for the decoder.
- Starts the EXU, waits for its completion, then gates the regfile write enable for one cycle.
- Halts on ebreak or an illegal instruction and counts retired instructions.

---
 rtl/core_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/core_ctrl.sv
// Multi-cycle sequencing controller: owns the PC, fetches over a valid/ready port,
// sequences decode/execute/writeback and halts on ebreak or an illegal instruction.
module core_ctrl #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic [XLEN-1:0] inst,
    output logic            inst_valid,
    input  logic            dec_ebreak,
    input  logic            dec_illegal,
    output logic            alu_start,
    input  logic            alu_done,
    output logic            rf_wen_gate,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instret,
    output logic            halted,
    output logic            halt_illegal
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_REQ,
        FETCH_WAIT,
        DECODE,
        EXEC,
        WB,
        HALT
    } state_t;

    state_t state;
    state_t state_next;
    logic   exec_seen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:       state_next = FETCH_REQ;
            FETCH_REQ:  if (imem_req_ready) state_next = FETCH_WAIT;
            FETCH_WAIT: if (imem_resp_valid) state_next = DECODE;
            DECODE:     state_next = (dec_ebreak || dec_illegal) ? HALT : EXEC;
            EXEC:       if (alu_done) state_next = WB;
            WB:         state_next = FETCH_REQ;
            HALT:       state_next = HALT;
            default:    state_next = IDLE;
        endcase
    end

    // exec_seen remembers that the previous cycle was already EXEC, so the
    // start pulse covers only the first EXEC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= RESET_PC;
            inst         <= '0;
            instret      <= '0;
            halted       <= 1'b0;
            halt_illegal <= 1'b0;
            exec_seen    <= 1'b0;
        end else begin
            exec_seen <= (state == EXEC);
            case (state)
                FETCH_WAIT: begin
                    if (imem_resp_valid) begin
                        inst <= imem_resp_data;
                    end
                end
                DECODE: begin
                    if (dec_ebreak) begin
                        halted <= 1'b1;
                    end else if (dec_illegal) begin
                        halted       <= 1'b1;
                        halt_illegal <= 1'b1;
                    end
                end
                WB: begin
                    pc      <= pc + {{(XLEN-3){1'b0}}, 3'b100};
                    instret <= instret + {{(XLEN-1){1'b0}}, 1'b1};
                end
                default: ;
            endcase
        end
    end

    assign imem_req_valid = (state == FETCH_REQ);
    assign imem_addr      = pc;
    assign inst_valid     = (state == DECODE) || (state == EXEC) || (state == WB);
    assign alu_start      = (state == EXEC) && !exec_seen;
    assign rf_wen_gate    = (state == WB);

endmodule
